fifo_splitter_n: RTL and testbench
==================================

# fifo_splitter_n

Parametrised N-way stream splitter with per-channel elastic buffering. One valid/ready input stream is copied into CHANNELS output streams. Each output has its own DEPTH-entry FIFO, so a stalled consumer only blocks the input once its buffer fills. A runtime enable mask selects which channels receive each word. It sits between a producer stage and several independent consumers in the backpropagation datapath, e.g. fanning an error vector out to weight-update and delta-propagation units.

## Interface
- DATA_WIDTH, 32, width of one data word
- CHANNELS, 2, number of output streams, ≥1
- DEPTH, 4, entries per channel FIFO, power of two, ≥2
- CW (local), $clog2(DEPTH)+1, width of one fill count

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- data_in  in  DATA_WIDTH  input word
- data_in_valid  in  1  input word valid
- data_in_ready  out  1  block accepts input this cycle
- out_enable  in  CHANNELS  bit i=1: channel i receives the accepted word; sampled only in the accept cycle
- data_out  out  CHANNELS*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- data_out_valid  out  CHANNELS  per-channel head valid
- data_out_ready  in  CHANNELS  per-channel consumer ready
- fill  out  CHANNELS*CW  channel i occupancy 0..DEPTH at [i*CW +: CW]

## Operation
- Per channel: circular buffer of DEPTH words, write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- data_in_ready = 1 when every channel with out_enable[i]=1 has count < DEPTH. Channels with out_enable[i]=0 are ignored.
- out_enable == 0: data_in_ready=1. Accepted words are discarded and no channel changes.
- Accept: data_in_valid && data_in_ready. The word is written to every enabled channel in the same cycle, so each enabled channel holds the identical word sequence.
- data_in_ready depends only on registered counts and out_enable. It does not depend on data_out_ready, so there is no combinational ready path from outputs to input.
- A full channel popping in the same cycle still holds data_in_ready low that cycle.
- Pop on channel i: data_out_valid[i] && data_out_ready[i]. The read pointer advances.
- data_out_valid[i] = (count_i != 0). data_out[i] is the word at read pointer i.
- Push and pop on one channel in the same cycle: count unchanged, both pointers advance. This is legal at any count 1..DEPTH-1; at count 0 only the push occurs, because valid was 0.
- Channels drain independently. Order within each channel is strict FIFO.
- data_out_ready while valid=0 has no effect.
- Count arithmetic is CW bits wide and never exceeds DEPTH or goes below 0.

## Timing
- Reset values (immediately on rst=0, asynchronous):
  - all counts and pointers 0
  - data_out_valid = 0, fill = 0
  - data_out = 0; storage cleared
  - data_in_ready = 0 while rst=0
- First cycle after rst returns to 1: data_in_ready=1.
- Reset mid-operation discards all buffered words in every channel.
- Latency: a word accepted at edge k is presented with data_out_valid=1 after edge k. There is no same-cycle fall-through.
- Throughput: one word per cycle sustained while all enabled consumers hold ready=1.
- fill updates on the same edge as the push or pop.

## Test plan
- Reset: drive rst=0 mid-stream with channels holding 3 words. Outputs go to valid=0, fill=0 without a clock edge. First cycle after release: data_in_ready=1.
- Broadcast, CHANNELS=3, DEPTH=4, out_enable=3'b111, all ready=1: send 0x10..0x1F back-to-back. Each channel emits 0x10..0x1F in order, one per cycle, one cycle behind input. data_in_ready stays 1 throughout.
- Backpressure:
  - Stimulus: ch1 ready=0, others 1; send 6 words.
  - Response: 4 accepted, then data_in_ready=0 and fill[ch1]=4. Other channels have drained all 4.
  - Raising ch1 ready for one cycle: data_in_ready still 0 that cycle (no bypass), 1 the next cycle, and the 5th word is accepted.
- Mask: send 0xA with out_enable=3'b001, 0xB with 3'b110, 0xC with 3'b000.
  - ch0 gets {0xA}; ch1 and ch2 get {0xB}.
  - 0xC is accepted with ready=1 and appears nowhere.
  - A full masked-off channel does not stall the input.
- Simultaneous push/pop at fill=2 on every channel: fill stays 2, order is preserved across pointer wrap. Run 3*DEPTH words to exercise wrap.
- Empty pop: data_out_ready=1 with fill=0 leaves fill=0 and valid=0; no underflow.

Source files
------------

// File: rtl/fifo_splitter_n.sv
// N-way stream splitter: one valid/ready input is copied into per-channel FIFOs
// selected by a runtime enable mask; each output drains independently.
module fifo_splitter_n #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [DATA_WIDTH-1:0]                      data_in,
    input  logic                                       data_in_valid,
    output logic                                       data_in_ready,
    input  logic [CHANNELS-1:0]                        out_enable,
    output logic [CHANNELS*DATA_WIDTH-1:0]             data_out,
    output logic [CHANNELS-1:0]                        data_out_valid,
    input  logic [CHANNELS-1:0]                        data_out_ready,
    output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]      fill
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q    [CHANNELS][DEPTH];
    logic [DATA_WIDTH-1:0] mem_d    [CHANNELS][DEPTH];
    logic [PW-1:0]         wr_ptr_q [CHANNELS];
    logic [PW-1:0]         wr_ptr_d [CHANNELS];
    logic [PW-1:0]         rd_ptr_q [CHANNELS];
    logic [PW-1:0]         rd_ptr_d [CHANNELS];
    logic [CW-1:0]         cnt_q    [CHANNELS];
    logic [CW-1:0]         cnt_d    [CHANNELS];

    logic                  all_room;
    logic                  accept;
    logic [CHANNELS-1:0]   push;
    logic [CHANNELS-1:0]   pop;

    // Ready looks only at registered counts and the mask, never at consumer ready.
    always_comb begin
        all_room = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (out_enable[c] && (cnt_q[c] == FullCount)) begin
                all_room = 1'b0;
            end
        end
        data_in_ready = rst & all_room;
        accept        = data_in_valid & data_in_ready;
        for (int c = 0; c < CHANNELS; c++) begin
            push[c] = accept & out_enable[c];
            pop[c]  = (cnt_q[c] != '0) & data_out_ready[c];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = data_in;
                wr_ptr_d[c]           = wr_ptr_q[c] + PW'(1);
            end
            if (pop[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
            end
            if (push[c] && !pop[c]) begin
                cnt_d[c] = cnt_q[c] + CW'(1);
            end else if (!push[c] && pop[c]) begin
                cnt_d[c] = cnt_q[c] - CW'(1);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            data_out[c*DATA_WIDTH +: DATA_WIDTH] = mem_q[c][rd_ptr_q[c]];
            data_out_valid[c]                    = (cnt_q[c] != '0);
            fill[c*CW +: CW]                     = cnt_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    mem_q[c][d] <= '0;
                end
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_splitter_n.sv
// Scoreboard bench for fifo_splitter_n: per-channel expected-word queues filled
// from observed accepts, drained by a monitor on observed pops.
module tb_fifo_splitter_n;

    localparam int DW = 32;
    localparam int CH = 3;
    localparam int DP = 4;
    localparam int CW = $clog2(DP) + 1;

    logic               clk;
    logic               rst;
    logic [DW-1:0]      data_in;
    logic               data_in_valid;
    logic               data_in_ready;
    logic [CH-1:0]      out_enable;
    logic [CH*DW-1:0]   data_out;
    logic [CH-1:0]      data_out_valid;
    logic [CH-1:0]      data_out_ready;
    logic [CH*CW-1:0]   fill;

    fifo_splitter_n #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .DEPTH      (DP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .out_enable     (out_enable),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .fill           (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    logic [DW-1:0] exp_q [CH][$];
    bit rand_ready = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the queue model and pops on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ready", 64'(data_in_ready), 64'd0);
            for (int c = 0; c < CH; c++) begin
                chk("rst_valid", 64'(data_out_valid[c]), 64'd0);
                chk("rst_fill", 64'(fill[c*CW +: CW]), 64'd0);
            end
        end else begin
            logic exp_rdy;
            exp_rdy = 1'b1;
            for (int c = 0; c < CH; c++) begin
                if (out_enable[c] && exp_q[c].size() >= DP) exp_rdy = 1'b0;
            end
            chk("in_ready", 64'(data_in_ready), 64'(exp_rdy));
            for (int c = 0; c < CH; c++) begin
                chk("out_valid", 64'(data_out_valid[c]), 64'(exp_q[c].size() != 0));
                chk("fill", 64'(fill[c*CW +: CW]), 64'(exp_q[c].size()));
                if (data_out_valid[c] && data_out_ready[c] && exp_q[c].size() != 0) begin
                    logic [DW-1:0] w;
                    w = exp_q[c].pop_front();
                    chk("data_out", 64'(data_out[c*DW +: DW]), 64'(w));
                end
            end
        end
    end

    // Scoreboard feeder: records every accepted word into the enabled channels.
    always @(negedge clk) begin
        #1;
        if (rst && data_in_valid && data_in_ready) begin
            for (int c = 0; c < CH; c++) begin
                if (out_enable[c]) exp_q[c].push_back(data_in);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 data_out_ready = 3'($urandom);
        end
    end

    task automatic send(input logic [DW-1:0] w, input logic [CH-1:0] en);
        int  t;
        logic acc;
        t = 0;
        acc = 1'b0;
        data_in = w;
        data_in_valid = 1'b1;
        out_enable = en;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = data_in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", w);
        end
        data_in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        data_in = '0;
        data_in_valid = 1'b0;
        out_enable = '0;
        data_out_ready = '0;
        cycles(3);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(data_in_ready), 64'd1);
        @(posedge clk); #1;

        // Reset mid-stream with three words buffered everywhere.
        for (int i = 0; i < 3; i++) send(32'h50 + 32'(i), 3'b111);
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", 64'(data_out_valid), 64'd0);
        chk("async_fill", 64'(fill), 64'd0);
        chk("async_data", 64'(data_out[31:0]), 64'd0);
        chk("async_ready", 64'(data_in_ready), 64'd0);
        for (int c = 0; c < CH; c++) exp_q[c].delete();
        cycles(2);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst2", 64'(data_in_ready), 64'd1);
        @(posedge clk); #1;

        // Broadcast at full rate.
        data_out_ready = 3'b111;
        for (int i = 0; i < 16; i++) send(32'h10 + 32'(i), 3'b111);
        cycles(3);

        // Backpressure on channel 1.
        data_out_ready = 3'b101;
        for (int i = 0; i < 4; i++) send(32'h20 + 32'(i), 3'b111);
        data_in_valid = 1'b1;
        cycles(2);
        @(negedge clk);
        chk("bp_fill1", 64'(fill[1*CW +: CW]), 64'd4);
        chk("bp_fill0", 64'(fill[0*CW +: CW]), 64'd0);
        chk("bp_ready", 64'(data_in_ready), 64'd0);
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        fork
            begin
                send(32'h24, 3'b111);
                send(32'h25, 3'b111);
            end
            begin
                cycles(2);
                data_out_ready = 3'b111;
                @(negedge clk);
                chk("no_bypass", 64'(data_in_ready), 64'd0);
                @(posedge clk); #1;
                data_out_ready = 3'b101;
                @(negedge clk);
                chk("ready_after_pop", 64'(data_in_ready), 64'd1);
                cycles(4);
                data_out_ready = 3'b111;
            end
        join
        cycles(8);

        // Mask selection, including an all-zero mask.
        send(32'hA, 3'b001);
        send(32'hB, 3'b110);
        send(32'hC, 3'b000);
        cycles(4);

        // Full masked-off channel must not stall the input.
        data_out_ready = 3'b011;
        for (int i = 0; i < 4; i++) send(32'h30 + 32'(i), 3'b100);
        data_in = 32'h34;
        out_enable = 3'b011;
        data_in_valid = 1'b1;
        @(negedge clk);
        chk("mask_full_fill2", 64'(fill[2*CW +: CW]), 64'd4);
        chk("mask_no_stall", 64'(data_in_ready), 64'd1);
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        data_out_ready = 3'b111;
        cycles(8);

        // Simultaneous push/pop at fill=2 across pointer wrap.
        data_out_ready = 3'b000;
        send(32'h40, 3'b111);
        send(32'h41, 3'b111);
        data_out_ready = 3'b111;
        for (int i = 0; i < 3 * DP; i++) begin
            send(32'h42 + 32'(i), 3'b111);
            chk("steady_fill", 64'(fill), 64'({3'd2, 3'd2, 3'd2}));
        end
        cycles(6);

        // Empty pop.
        @(negedge clk);
        chk("empty_fill", 64'(fill), 64'd0);
        chk("empty_valid", 64'(data_out_valid), 64'd0);
        @(posedge clk); #1;

        // Randomized traffic with random masks and consumer stalls.
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) cycles($urandom_range(1, 3));
            send($urandom, 3'($urandom));
        end
        rand_ready = 0;
        @(posedge clk); #2;
        data_out_ready = 3'b111;
        cycles(DP + 4);
        for (int c = 0; c < CH; c++) chk("drained", 64'(exp_q[c].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
